// File: rtl/keyseq_responder.sv
// Bus-keyed LFSR responder: locked/sync/run FSM gated by an address-nibble unlock sequence.
// Optional idle relock is compiled in with `define KEYSEQ_TIMEOUT_EN.
module keyseq_responder #(
    parameter int                 STATE_W    = 8,
    parameter logic [STATE_W-1:0] TAPS       = 8'hB8,
    parameter logic [STATE_W-1:0] SEED       = 8'h01,
    parameter int                 DATA_W     = 2,
    parameter logic [3:0]         START_NIB  = 4'hA,
    parameter int                 UNLOCK_LEN = 4,
    parameter int                 TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_stb,
    input  logic              bus_sel,
    input  logic              bus_rnw,
    input  logic [3:0]        bus_addr,
    output logic              rd_oe,
    output logic [DATA_W-1:0] rd_data,
    output logic              unlocked
);

    typedef enum logic [1:0] {LOCK, SYNC, RUN} state_t;

    localparam logic [3:0] LAST_MATCH = 4'(UNLOCK_LEN - 1);

    if (STATE_W < 6 || DATA_W < 1 || DATA_W > STATE_W || SEED == '0 ||
        UNLOCK_LEN < 1 || UNLOCK_LEN > 15 || TIMEOUT < 1) begin : g_bad_params
        $error("keyseq_responder: illegal parameter combination");
    end

    state_t             state, state_nxt;
    logic [STATE_W-1:0] s, s_nxt;
    logic [3:0]         cnt, cnt_nxt;
    logic               qr, qw, expire;

    function automatic logic [STATE_W-1:0] lfsr_nxt(input logic [STATE_W-1:0] x);
        return {x[STATE_W-2:0], ^(x & TAPS)};
    endfunction

    // An all-zero LFSR would stick forever, so any zero result reloads the seed.
    function automatic logic [STATE_W-1:0] zguard(input logic [STATE_W-1:0] x);
        return (x == '0) ? SEED : x;
    endfunction

    function automatic logic [DATA_W-1:0] resp_of(input logic [STATE_W-1:0] x);
        logic [STATE_W-1:0] rt;
        logic [DATA_W-1:0]  r;
        rt = TAPS;
        r  = '0;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = ^(x & rt);
            rt   = {rt[STATE_W-2:0], rt[STATE_W-1]};
        end
        return r;
    endfunction

    assign qr = bus_stb & bus_sel & bus_rnw;
    assign qw = bus_stb & bus_sel & ~bus_rnw;

`ifdef KEYSEQ_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    logic [IDLE_W-1:0] idle;

    // A qualified access in the expiry cycle wins over the timeout.
    assign expire = (state != LOCK) && !(qr || qw) && (idle == IDLE_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || qr || qw || state == LOCK || expire) begin
            idle <= '0;
        end else begin
            idle <= idle + 1'b1;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        s_nxt     = s;
        cnt_nxt   = cnt;
        case (state)
            LOCK: begin
                if (qr && bus_addr == START_NIB) begin
                    state_nxt = SYNC;
                    s_nxt     = SEED;
                    cnt_nxt   = '0;
                end
            end
            SYNC: begin
                if (qr && bus_addr == s[3:0]) begin
                    s_nxt   = zguard(lfsr_nxt(s));
                    cnt_nxt = cnt + 4'd1;
                    if (cnt == LAST_MATCH) begin
                        state_nxt = RUN;
                    end
                end else if (qr || qw) begin
                    state_nxt = LOCK;
                    s_nxt     = SEED;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                if (qr) begin
                    s_nxt = zguard(lfsr_nxt(s) ^ STATE_W'(bus_addr));
                end else if (qw && bus_addr == 4'hF) begin
                    state_nxt = LOCK;
                    s_nxt     = SEED;
                end
            end
            default: begin
                state_nxt = LOCK;
                s_nxt     = SEED;
                cnt_nxt   = '0;
            end
        endcase
        if (expire) begin
            state_nxt = LOCK;
            s_nxt     = SEED;
            cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOCK;
            s     <= SEED;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            s     <= s_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign rd_oe    = bus_sel & bus_rnw;
    assign rd_data  = (state == LOCK) ? '0 : resp_of(s);
    assign unlocked = (state == RUN);

endmodule

// File: doc/keyseq_responder.md
# keyseq_responder

Parametrised bus-keyed sequence responder for the expansion-bus decode area. Each qualified bus cycle advances an LFSR state register and returns response bits computed from that state. The block adds a locked / sync / run state machine with a configurable unlock sequence, address-nibble mixing, software relock and an optional idle timeout. It replaces fixed-width, fixed-sequence decoders with one configurable block.

## Interface
Parameters:
- STATE_W, 8: LFSR state width. Minimum 6.
- TAPS, 8'hB8: feedback tap mask. STATE_W bits.
- SEED, 8'h01: reset and reload state. Must be nonzero.
- DATA_W, 2: number of response bits, 1..STATE_W.
- START_NIB, 4'hA: address nibble that opens the unlock sequence.
- UNLOCK_LEN, 4: number of matching reads needed to unlock, 1..15.
- TIMEOUT, 1024: idle cycles before automatic relock. Used only with the timeout option.

Ports:
- clk, in, 1: the single clock. All state updates on its rising edge.
- rst, in, 1: reset. **Synchronous and active-high.**
- bus_stb, in, 1: one-cycle strobe per bus access.
- bus_sel, in, 1: window decode (device selected).
- bus_rnw, in, 1: 1 = read, 0 = write.
- bus_addr, in, 4: address nibble (bus address bits 7..4).
- rd_oe, out, 1: response drive enable. Combinational: bus_sel & bus_rnw.
- rd_data, out, DATA_W: response bits. Combinational from the current state.
- unlocked, out, 1: high while the FSM is in RUN.

## Operation
- Qualified read (QR): bus_stb & bus_sel & bus_rnw.
- Qualified write (QW): bus_stb & bus_sel & ~bus_rnw.
- Unqualified cycles leave all state unchanged.
- LFSR step: nxt(s) = {s[STATE_W-2:0], ^(s & TAPS)}.
- Response bit i: resp[i] = ^(s & rotl(TAPS, i)).
- Response masking: rd_data = resp in SYNC and RUN; rd_data = 0 in LOCK.
- Zero guard: any state update whose result is 0 loads SEED instead.

State machine (lock state, LFSR state s, match count cnt; cnt is 4 bits):
- **LOCK**
  - QR with bus_addr == START_NIB → SYNC; s ← SEED; cnt ← 0.
  - All other accesses are ignored.
- **SYNC**
  - QR with bus_addr == s[3:0] → s ← nxt(s); cnt ← cnt+1. If cnt == UNLOCK_LEN-1, go to RUN.
  - QR with any other nibble → LOCK; s ← SEED; cnt ← 0.
  - QW → LOCK; s ← SEED; cnt ← 0.
- **RUN**
  - QR → s ← nxt(s) ^ {{STATE_W-4{0}}, bus_addr}, subject to the zero guard.
  - QW with bus_addr == 4'hF → LOCK; s ← SEED.
  - Other QWs are ignored.

## Timing
- Reset values: state LOCK, s = SEED, cnt = 0, rd_data = 0, unlocked = 0. rd_oe follows its inputs.
- rst takes priority over any simultaneous bus activity. Asserting rst during SYNC or RUN returns to LOCK on that edge.
- Response latency: rd_data shows resp(s) for the state *before* the edge that consumes the QR. The new state is visible on the cycle after the strobe.
- At most one state update per clock.
- Back-to-back strobes on consecutive cycles are legal; each one is processed.
- unlocked rises on the cycle after the final matching QR. It falls on the cycle after a relock.
- The SYNC → RUN edge also performs that read's LFSR step.

## Configuration
- Macro: KEYSEQ_TIMEOUT_EN.
- With the macro defined:
  - An idle counter of width clog2(TIMEOUT+1) clears on every qualified access and on entry to SYNC or RUN.
  - It counts only in SYNC or RUN.
  - On reaching TIMEOUT it forces LOCK, s ← SEED, cnt ← 0 on the next edge.
  - A qualified access in the same cycle as the expiry wins: it is processed and the counter clears.
- Without the macro: no counter exists, SYNC and RUN persist indefinitely, and the TIMEOUT parameter is unused.

## Test plan
All scenarios use the default parameters.
- Reset check: assert rst for 2 cycles → rd_data = 0, unlocked = 0, s = 8'h01. A QR with addr 4'h3 in LOCK changes nothing.
- Unlock: QR addrs A, 1, 2, 4, 8 → unlocked = 1 on the cycle after the 4th match. s = 8'h11 and rd_data = 2'b01.
- Bad sequence: QR addrs A, 1, 3 → LOCK after the third read, rd_data = 0, and a later QR with addr 2 has no effect.
- RUN mixing and relock:
  - Unlock as in the unlock scenario, then QR with addr 4'h0 → s = 8'h23.
  - QW with addr 4'h7 → still RUN.
  - QW with addr 4'hF → unlocked = 0 on the next cycle, s = 8'h01.
- Reset mid-sequence: QR A, 1, then rst asserted in the same cycle as QR 2 → LOCK, s = 8'h01, and QR 2 has no effect.
- Timeout (KEYSEQ_TIMEOUT_EN, TIMEOUT = 16):
  - Unlock, then idle 15 cycles → unlocked still 1.
  - Idle one more cycle → unlocked = 0.
  - Repeat the unlock with a QR on cycle 16 → stays unlocked.
